// File: rtl/ocram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port on-chip RAM.
// One grant per cycle; reads return two cycles after their grant.
module ocram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata
);
    localparam int BE_W = DATA_W / 8;

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              grant;
    logic              win;
    logic              win_write;
    logic              win_read;

    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_owner_q, s1_owner_d;
    logic              rdv0_q, rdv0_d;
    logic              rdv1_q, rdv1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && (!req1 || last_grant_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        grant     = gnt0 | gnt1;
        win       = gnt1;
        win_write = win ? m1_write : m0_write;
        // A simultaneous read+write is a plain write with no read return.
        win_read  = (win ? m1_read : m0_read) & ~win_write;

        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        if (grant) begin
            last_grant_d = win;
            addr_d       = win ? m1_address    : m0_address;
            be_d         = win ? m1_byteenable : m0_byteenable;
            wdata_d      = win ? m1_writedata  : m0_writedata;
        end

        s1_valid_d = grant & win_read;
        s1_owner_d = win;
        rdv0_d     = s1_valid_q & ~s1_owner_q;
        rdv1_d     = s1_valid_q & s1_owner_q;
        rdata0_d   = rdv0_d ? ram_readdata : rdata0_q;
        rdata1_d   = rdv1_d ? ram_readdata : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_owner_q   <= 1'b0;
            rdv0_q       <= 1'b0;
            rdv1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_owner_q   <= s1_owner_d;
            rdv0_q       <= rdv0_d;
            rdv1_q       <= rdv1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // RAM-side address/data are don't-care when idle; they just hold.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
    end

    assign ram_address      = addr_d;
    assign ram_byteenable   = be_d;
    assign ram_writedata    = wdata_d;
    assign ram_chipselect   = grant;
    assign ram_write        = grant & win_write;
    assign ram_clken        = ~reset;

    assign m0_waitrequest   = ~gnt0;
    assign m1_waitrequest   = ~gnt1;
    assign m0_readdatavalid = rdv0_q & ~reset;
    assign m1_readdatavalid = rdv1_q & ~reset;
    assign m0_readdata      = reset ? '0 : rdata0_q;
    assign m1_readdata      = reset ? '0 : rdata1_q;

endmodule

// File: tb/tb_ocram_arbiter.sv
// Scoreboard bench for ocram_arbiter: reference model predicts grants,
// RAM strobes and read returns; a negedge monitor compares.
module tb_ocram_arbiter;
    localparam int AW = 13;
    localparam int DW = 16;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic          m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteenable;
    logic [DW-1:0] ram_writedata;
    logic          ram_chipselect, ram_write, ram_clken;
    logic [DW-1:0] ram_readdata;

    always #5 clk = ~clk;

    ocram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    // RAM with registered address and unregistered output
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_raddr = '0;
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write && ram_byteenable[0]) ram_mem[ram_address][7:0] <= ram_writedata[7:0];
            if (ram_write && ram_byteenable[1]) ram_mem[ram_address][15:8] <= ram_writedata[15:8];
            ram_raddr <= ram_address;
        end
    end
    assign ram_readdata = ram_mem[ram_raddr];

    typedef struct {
        bit rst;
        bit r0, w0, r1, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [BW-1:0] b0, b1;
    } stim_t;

    typedef struct {
        bit rst, g0, g1, we, have;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
    } exp_t;

    typedef struct {
        bit port;
        logic [DW-1:0] data;
        int due;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_last = 1'b1;
    bit            m_have = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    logic [BW-1:0] m_be = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        rd_t  r;
        bit q0, q1, w, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        @(posedge clk);
        #1;
        reset = s.rst;
        m0_read = s.r0; m0_write = s.w0; m0_address = s.a0;
        m0_writedata = s.d0; m0_byteenable = s.b0;
        m1_read = s.r1; m1_write = s.w1; m1_address = s.a1;
        m1_writedata = s.d1; m1_byteenable = s.b1;
        e = '{default: '0};
        e.rst = s.rst;
        if (s.rst) begin
            m_last = 1'b1;
            for (int i = rd_q.size() - 1; i >= 0; i--)
                if (rd_q[i].due >= cyc) rd_q.delete(i);
        end else begin
            q0 = s.r0 | s.w0;
            q1 = s.r1 | s.w1;
            if (q0 || q1) begin
                w = (q0 && q1) ? !m_last : q1;
                m_last = w;
                e.g0 = !w;
                e.g1 = w;
                wr = w ? s.w1 : s.w0;
                a = w ? s.a1 : s.a0;
                d = w ? s.d1 : s.d0;
                b = w ? s.b1 : s.b0;
                e.we = wr;
                if (wr) begin
                    if (b[0]) ref_mem[a][7:0] = d[7:0];
                    if (b[1]) ref_mem[a][15:8] = d[15:8];
                end else begin
                    r.port = w;
                    r.data = ref_mem[a];
                    r.due = cyc + 2;
                    rd_q.push_back(r);
                end
                m_addr = a; m_wd = d; m_be = b; m_have = 1'b1;
            end
        end
        e.have = m_have;
        e.addr = m_addr;
        e.wd = m_wd;
        e.be = m_be;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(nop());
    endtask

    always @(negedge clk) begin
        exp_t e;
        rd_t  r;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("waitrequest0", m0_waitrequest, !e.g0);
            chk("waitrequest1", m1_waitrequest, !e.g1);
            chk("chipselect", ram_chipselect, e.g0 | e.g1);
            chk("ram_write", ram_write, e.we);
            chk("clken", ram_clken, !e.rst);
            if (e.rst) begin
                chk("rst_readdata0", m0_readdata, 0);
                chk("rst_readdata1", m1_readdata, 0);
            end else if (e.have) begin
                chk("ram_address", ram_address, e.addr);
                chk("ram_writedata", ram_writedata, e.wd);
                chk("ram_byteenable", ram_byteenable, e.be);
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                r = rd_q.pop_front();
                chk("readdatavalid0", m0_readdatavalid, !r.port);
                chk("readdatavalid1", m1_readdatavalid, r.port);
                if (r.port) chk("readdata1", m1_readdata, r.data);
                else chk("readdata0", m0_readdata, r.data);
            end else begin
                chk("readdatavalid0_idle", m0_readdatavalid, 0);
                chk("readdatavalid1_idle", m1_readdatavalid, 0);
            end
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        s = nop(); s.rst = 1;
        repeat (3) step(s);

        // contention from reset release: 0,1,0,1
        s = nop();
        s.w0 = 1; s.a0 = 13'h0100; s.d0 = 16'h0a0a; s.b0 = 2'b11;
        s.w1 = 1; s.a1 = 13'h0200; s.d1 = 16'h0b0b; s.b1 = 2'b11;
        repeat (4) step(s);

        // read latency
        s = nop(); s.w0 = 1; s.a0 = 13'h0010; s.d0 = 16'hBEEF; s.b0 = 2'b11;
        step(s);
        s = nop(); s.r0 = 1; s.a0 = 13'h0010;
        step(s);
        idle(3);

        // byte enables at the top word
        s = nop(); s.w1 = 1; s.a1 = 13'h1FFF; s.d1 = 16'h1234; s.b1 = 2'b11;
        step(s);
        s.d1 = 16'hABCD; s.b1 = 2'b10;
        step(s);
        s = nop(); s.r1 = 1; s.a1 = 13'h1FFF;
        step(s);
        idle(3);

        // interleaved reads
        s = nop();
        s.w0 = 1; s.a0 = 13'h0001; s.d0 = 16'h1111; s.b0 = 2'b11;
        s.w1 = 1; s.a1 = 13'h0002; s.d1 = 16'h2222; s.b1 = 2'b11;
        step(s);
        step(s);
        s = nop(); s.r0 = 1; s.a0 = 13'h0001; s.r1 = 1; s.a1 = 13'h0002;
        repeat (6) step(s);
        idle(3);

        // reset right after a port 1 read grant
        s = nop(); s.r1 = 1; s.a1 = 13'h0002;
        step(s);
        s = nop(); s.rst = 1;
        step(s);
        idle(3);
        s = nop();
        s.w0 = 1; s.a0 = 13'h0030; s.d0 = 16'h3030; s.b0 = 2'b11;
        s.w1 = 1; s.a1 = 13'h0031; s.d1 = 16'h3131; s.b1 = 2'b11;
        step(s);
        idle(2);

        // read and write together
        s = nop(); s.r0 = 1; s.w0 = 1; s.a0 = 13'h0005; s.d0 = 16'h5555; s.b0 = 2'b11;
        step(s);
        idle(3);
        s = nop(); s.r0 = 1; s.a0 = 13'h0005;
        step(s);
        idle(3);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            s = nop();
            s.rst = ($urandom % 60) == 0;
            s.r0 = ($urandom % 3) == 0;
            s.w0 = ($urandom % 3) == 0;
            s.r1 = ($urandom % 3) == 0;
            s.w1 = ($urandom % 3) == 0;
            s.a0 = ($urandom % 2) ? AW'($urandom % 16) : AW'(13'h1FF0 + ($urandom % 16));
            s.a1 = ($urandom % 2) ? AW'($urandom % 16) : AW'(13'h1FF0 + ($urandom % 16));
            s.d0 = DW'($urandom);
            s.d1 = DW'($urandom);
            s.b0 = BW'($urandom);
            s.b1 = BW'($urandom);
            step(s);
        end
        idle(5);
        @(negedge clk);
        #1;
        chk("reads_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
